mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-port arbiter that shares the single-port data memory (MemRead/MemWrite/Address/WD/RD) between two requesters, e.g. the load/store unit and a DMA/debug loader. Each requester uses a valid/ack handshake; the arbiter picks a winner round-robin, sequences one memory access at a time and returns read data with a one-cycle ack. It sits between the pipeline's memory stage and the memory block, replacing a direct connection.

Parameters:
WIDTH, 32, data word width (WD/RD/wdata/rdata)
DEPTH, 16, address width in bits
RD_LAT, 1, cycles from MemRead-asserted cycle to RD valid; legal range 1..4

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  2  per-port request valid; bit i = port i
req_we  input  2  per-port 1 = write, 0 = read
req_addr0, req_addr1  input  DEPTH  per-port word address
req_wdata0, req_wdata1  input  WIDTH  per-port write data
ack  output  2  per-port one-cycle completion pulse
rdata0, rdata1  output  WIDTH  per-port read data, valid when ack[i]=1
MemRead  output  1  memory read enable
MemWrite  output  1  memory write enable
Address  output  DEPTH  memory address
WD  output  WIDTH  memory write data
RD  input  WIDTH  memory read data
busy  output  1  high whenever state != IDLE

Behaviour:
- All outputs registered. Reset (rst=1 at a rising edge): state=IDLE, ack=0, rdata0/1=0, MemRead=0, MemWrite=0, Address=0, WD=0, busy=0, last_grant=1 (port 0 wins the first tie).
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: if any req_valid, select winner, latch its we/addr/wdata, go ACCESS; else stay.
- Selection: one valid -> that port. Both valid -> port != last_grant. last_grant updated on entry to ACCESS.
- ACCESS (exactly 1 cycle): Address/WD driven from latch; MemWrite=we, MemRead=!we. Write -> DONE. Read -> WAIT with counter=RD_LAT.
- WAIT: MemRead=0, Address held. Counter decrements each cycle; in the cycle it reaches 1, RD is captured into the winner's rdata register; next state DONE.
- DONE (1 cycle): ack[winner]=1, rdata stable; go IDLE. rdata of the non-winner is unchanged.
- Latency, request sampled in IDLE cycle N: write -> MemWrite in N+1, ack in N+2. Read -> MemRead in N+1, ack in N+2+RD_LAT.
- Throughput: one access per 3 cycles (write) or 3+RD_LAT (read); IDLE cycle always between accesses.
- MemRead and MemWrite never both high; each is high for exactly one cycle per access.
- Handshake: requester holds valid/we/addr/wdata stable until ack. req_valid still high in the cycle after ack counts as a new request. Changes to inputs after latch are ignored for the in-flight access.
- Reset mid-operation: in-flight access abandoned, no ack issued, arbiter returns to IDLE next cycle with reset values.
- Address/WD hold last driven values in IDLE; they are don't-care when enables are low.

Optional Feature:
ARB_FIXED_PRIO_EN: when defined, port 0 always wins when both ports are valid and last_grant is unused. Port 1 can starve. When undefined, round-robin as specified above.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ACCESS, WAIT, DONE), port index type (1 bit), RD_LAT legal-range constants.
- One sub-module: mem_arb_pick. It is combinational 2-way winner select from req_valid and last_grant, and contains the ARB_FIXED_PRIO_EN switch.

Test Plan:
- Reset: rst held 2 cycles -> all outputs 0, busy=0. Release with no requests -> MemRead/MemWrite stay 0.
- Port 0 writes 0xDEADBEEF to 0x0010 in cycle N -> MemWrite=1, Address=0x0010, WD=0xDEADBEEF in N+1 only; ack=2'b01 in N+2. Then port 0 reads 0x0010 -> ack0 in N'+3 with rdata0=0xDEADBEEF (RD_LAT=1).
- Both ports read (0x0001 and 0x0002) held valid after reset -> port 0 acked first, then port 1. Over 4 continuous requests the grant order is 0,1,0,1.
- RD_LAT=3: port 1 reads 0x00FF holding 0x12345678 -> ack=2'b10 at N+5 with rdata1=0x12345678. rdata0 unchanged.
- rst asserted during WAIT of a port 0 read -> no ack, MemRead=0. The next port 0 request is served with normal latency.
- ARB_FIXED_PRIO_EN defined, both ports continuously valid -> only port 0 is acked over 6 accesses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter: FSM states, port index and read-latency limits.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } arb_state_e;

  typedef logic port_idx_t;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way winner select. Round-robin on ties by default;
// ARB_FIXED_PRIO_EN makes port 0 always win a tie (port 1 may starve).
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_valid_i,
  input  port_idx_t  last_grant_i,
  output logic       any_o,
  output port_idx_t  winner_o
);

`ifdef ARB_FIXED_PRIO_EN
  port_idx_t unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  always_comb begin
    any_o    = |req_valid_i;
    winner_o = 1'b0;
    case (req_valid_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
      2'b11:   winner_o = 1'b0;
`else
      2'b11:   winner_o = ~last_grant_i;
`endif
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port data memory between two valid/ack requesters, one access at a time.
// Optional build macro ARB_FIXED_PRIO_EN selects fixed priority (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_we,
  input  logic [DEPTH-1:0] req_addr0,
  input  logic [DEPTH-1:0] req_addr1,
  input  logic [WIDTH-1:0] req_wdata0,
  input  logic [WIDTH-1:0] req_wdata1,
  output logic [1:0]       ack,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [DEPTH-1:0] Address,
  output logic [WIDTH-1:0] WD,
  input  logic [WIDTH-1:0] RD,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(RD_LAT_MAX + 1);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("mem_arbiter: RD_LAT outside legal range");
  end

  arb_state_e       state_q, state_d;
  port_idx_t        grant_q, grant_d;
  port_idx_t        last_grant_q, last_grant_d;
  logic             we_q, we_d;
  logic [DEPTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ack_q, ack_d;
  logic [WIDTH-1:0] rdata0_q, rdata0_d;
  logic [WIDTH-1:0] rdata1_q, rdata1_d;
  logic             mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;
  logic             busy_q, busy_d;

  logic      any_req;
  port_idx_t winner;

  mem_arb_pick u_pick (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .any_o        (any_req),
    .winner_o     (winner)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    ack_d        = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // Enables are registered, so they are set while leaving IDLE to be live in ACCESS.
        if (any_req) begin
          state_d      = ACCESS;
          grant_d      = winner;
          last_grant_d = winner;
          we_d         = req_we[winner];
          addr_d       = winner ? req_addr1 : req_addr0;
          wdata_d      = winner ? req_wdata1 : req_wdata0;
          mem_wr_d     = req_we[winner];
          mem_rd_d     = ~req_we[winner];
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d        = DONE;
          ack_d[grant_q] = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LAT);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d        = DONE;
          ack_d[grant_q] = 1'b1;
          if (grant_q) rdata1_d = RD;
          else         rdata0_d = RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      ack_q        <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      busy_q       <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign MemRead  = mem_rd_q;
  assign MemWrite = mem_wr_q;
  assign Address  = addr_q;
  assign WD       = wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected acks; a monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 16;
  localparam int RD_LAT = 3;
  localparam int NACC   = 6;

  localparam logic [31:0] D_ADDR1 = 32'h1111_0001;
  localparam logic [31:0] D_ADDR2 = 32'h2222_0002;
  localparam logic [31:0] D_ADDRF = 32'h1234_5678;
  localparam logic [31:0] D_WR    = 32'hDEAD_BEEF;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_we;
  logic [DEPTH-1:0] req_addr0, req_addr1;
  logic [WIDTH-1:0] req_wdata0, req_wdata1;
  logic [1:0]       ack;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic             MemRead, MemWrite;
  logic [DEPTH-1:0] Address;
  logic [WIDTH-1:0] WD, RD;
  logic             busy;

  mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .ack(ack), .rdata0(rdata0), .rdata1(rdata1),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .WD(WD),
    .RD(RD), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: write on MemWrite, read data appears RD_LAT cycles after the MemRead cycle.
  logic [WIDTH-1:0] mem [0:(1<<DEPTH)-1];
  logic [WIDTH-1:0] rd_pipe [RD_LAT];
  logic [RD_LAT-1:0] rd_v = '0;
  always @(posedge clk) begin
    if (cyc == 0) begin
      mem[1]      <= D_ADDR1;
      mem[2]      <= D_ADDR2;
      mem[16'hFF] <= D_ADDRF;
    end
    if (MemWrite) mem[Address] <= WD;
    rd_pipe[0] <= mem[Address];
    rd_v[0]    <= MemRead;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      rd_v[i]    <= rd_v[i-1];
    end
  end
  assign RD = rd_v[RD_LAT-1] ? rd_pipe[RD_LAT-1] : 32'hBAD0_BAD0;

  typedef struct {
    int          port;
    logic        rd;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  logic [31:0] shadow0 = '0;
  logic [31:0] shadow1 = '0;
  logic [1:0]  exp_ack;
  logic [31:0] act_rd, act_other, exp_other;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ack(input int port, input logic rd, input logic [31:0] data, input int at);
    exp_t x;
    x.port = port;
    x.rd   = rd;
    x.data = data;
    x.at   = at;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: enable exclusivity, pulse counts, and ack/rdata against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      shadow0 = '0;
      shadow1 = '0;
    end
    if (MemRead) rd_pulses++;
    if (MemWrite) wr_pulses++;
    if (MemRead || MemWrite) begin
      checks++;
      if (MemRead && MemWrite) begin
        errors++;
        $display("FAIL mem_en_excl: MemRead=%b MemWrite=%b required not both (cycle %0d)",
                 MemRead, MemWrite, cyc);
      end
    end
    if (ack != 2'b00) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: ack=%b required 00 (cycle %0d)", ack, cyc);
      end else begin
        e = sb.pop_front();
        exp_ack = (e.port == 1) ? 2'b10 : 2'b01;
        if (ack !== exp_ack || cyc != e.at) begin
          errors++;
          $display("FAIL ack: ack=%b at cycle %0d required %b at cycle %0d", ack, cyc, exp_ack, e.at);
        end
        if (e.rd) begin
          checks++;
          act_rd = (e.port == 1) ? rdata1 : rdata0;
          if (act_rd !== e.data) begin
            errors++;
            $display("FAIL rdata%0d: got %h expected %h", e.port, act_rd, e.data);
          end
          if (e.port == 1) shadow1 = e.data;
          else             shadow0 = e.data;
        end
        checks++;
        act_other = (e.port == 1) ? rdata0 : rdata1;
        exp_other = (e.port == 1) ? shadow0 : shadow1;
        if (act_other !== exp_other) begin
          errors++;
          $display("FAIL rdata_other: got %h expected %h (cycle %0d)", act_other, exp_other, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int port;
    rst = 1'b1;
    req_valid = 2'b00; req_we = 2'b00;
    req_addr0 = '0; req_addr1 = '0;
    req_wdata0 = '0; req_wdata1 = '0;

    // Reset held two cycles
    tick(2);
    chk("rst_ack", ack, 2'b00);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_memread", MemRead, 0);
    chk("rst_memwrite", MemWrite, 0);
    chk("rst_address", Address, 0);
    chk("rst_wd", WD, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick(3);
    chk("idle_memread", MemRead, 0);
    chk("idle_memwrite", MemWrite, 0);
    chk("idle_busy", busy, 0);

    // Port 0 write then read back
    n = cyc;
    req_valid = 2'b01; req_we = 2'b01; req_addr0 = 16'h0010; req_wdata0 = D_WR;
    expect_ack(0, 1'b0, '0, n + 2);
    tick(1);
    chk("wr_memwrite", MemWrite, 1);
    chk("wr_memread", MemRead, 0);
    chk("wr_address", Address, 16'h0010);
    chk("wr_wd", WD, D_WR);
    chk("wr_busy", busy, 1);
    tick(1);
    chk("wr_memwrite_off", MemWrite, 0);
    req_valid = 2'b00;
    tick(1);
    n = cyc;
    req_valid = 2'b01; req_we = 2'b00; req_wdata0 = 32'h0BAD_F00D;
    expect_ack(0, 1'b1, D_WR, n + 2 + RD_LAT);
    tick(1);
    chk("rd_memread", MemRead, 1);
    chk("rd_address", Address, 16'h0010);
    req_addr0 = 16'h0002;
    tick(1);
    chk("rd_memread_off", MemRead, 0);
    chk("rd_address_held", Address, 16'h0010);
    tick(RD_LAT);
    req_valid = 2'b00;
    tick(1);

    // Both ports continuously valid after reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n = cyc;
    req_valid = 2'b11; req_we = 2'b00; req_addr0 = 16'h0001; req_addr1 = 16'h0002;
    for (int k = 0; k < NACC; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      port = 0;
`else
      port = k % 2;
`endif
      expect_ack(port, 1'b1, (port == 1) ? D_ADDR2 : D_ADDR1, n + 2 + RD_LAT + k * (3 + RD_LAT));
    end
    tick(2 + RD_LAT + (NACC - 1) * (3 + RD_LAT));
    req_valid = 2'b00;
    tick(1);

    // Port 1 single read, rdata0 must stay put
    n = cyc;
    req_valid = 2'b10; req_we = 2'b00; req_addr1 = 16'h00FF;
    expect_ack(1, 1'b1, D_ADDRF, n + 2 + RD_LAT);
    tick(2 + RD_LAT);
    req_valid = 2'b00;
    tick(1);

    // Reset during WAIT abandons the access
    n = cyc;
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = 16'h0002;
    tick(2);
    chk("abort_busy", busy, 1);
    chk("abort_memread_wait", MemRead, 0);
    rst = 1'b1; req_valid = 2'b00;
    tick(1);
    rst = 1'b0;
    chk("abort_busy_clr", busy, 0);
    chk("abort_ack", ack, 2'b00);
    chk("abort_memread", MemRead, 0);
    chk("abort_rdata0", rdata0, 0);
    tick(RD_LAT + 3);
    n = cyc;
    req_valid = 2'b01; req_addr0 = 16'h0001;
    expect_ack(0, 1'b1, D_ADDR1, n + 2 + RD_LAT);
    tick(1);
    chk("post_abort_memread", MemRead, 1);
    tick(1 + RD_LAT);
    req_valid = 2'b00;
    tick(3);

    chk("sb_drained", sb.size(), 0);
    chk("memread_pulses", rd_pulses, NACC + 4);
    chk("memwrite_pulses", wr_pulses, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
